shift_add_multiplier: RTL and testbench

Sequential unsigned shift-and-add multiplier for the 4-bit datapath; produces an 8-bit product over a fixed number of cycles.
The block does not contain an adder. It drives the operands of the existing 8-bit ripple adder instance (carry-in tied to 0) and registers that adder's sum each iteration, so it sits both directly upstream and directly downstream of the adder.
A Start/Busy/Done handshake lets the control unit launch an operation and collect the result.

---
 rtl/shift_add_multiplier.sv | 122 ++++++++++++
 tb/tb_shift_add_multiplier.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/shift_add_multiplier.sv
// Purpose: sequential unsigned shift-and-add multiplier, WIDTH x WIDTH -> 2*WIDTH, using an external adder.
// Latency: Start sampled at edge k, Done pulses in the cycle after edge k+WIDTH; one result per WIDTH+1 cycles.
// Backpressure: none; Start is ignored while Busy, and a new Start is accepted in IDLE or in the Done cycle.
//
// Ports:
//   Clock   - system clock, rising edge
//   Reset   - asynchronous, active-high reset
//   Start   - launch a new multiplication (accepted in IDLE or DONE)
//   A, B    - multiplicand / multiplier, captured when Start is accepted
//   AdderA  - operand 1 to the external 2*WIDTH-bit adder (running accumulator)
//   AdderB  - operand 2 to the external adder (shifted multiplicand or zero)
//   AdderS  - combinational sum returned by the external adder (carry-in 0, carry-out unused)
//   P       - product register, held until the next completion or reset
//   Busy    - high while iterating
//   Done    - one-cycle pulse when P holds a new result
//
// WIDTH must be 4 when paired with the existing 8-bit ripple adder.

module shift_add_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic [2*WIDTH-1:0]   AdderA,
    output logic [2*WIDTH-1:0]   AdderB,
    input  logic [2*WIDTH-1:0]   AdderS,
    output logic [2*WIDTH-1:0]   P,
    output logic                 Busy,
    output logic                 Done
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [PW-1:0]      r_acc;
    logic [PW-1:0]      r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [CW-1:0]      r_count;
    logic [PW-1:0]      r_p;
    logic               r_busy;
    logic               r_done;

    logic               w_run;

    assign w_run = (r_state == RUN);

    // The adder is only fed while iterating; outside RUN both operands are
    // held at zero so the shared adder sees a quiet input.
    assign AdderA = w_run ? r_acc : '0;
    assign AdderB = (w_run && r_mplier[0]) ? r_mcand : '0;

    assign P    = r_p;
    assign Busy = r_busy;
    assign Done = r_done;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state  <= IDLE;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_count  <= '0;
            r_p      <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                // DONE behaves like IDLE for acceptance, which gives
                // back-to-back operations with no idle gap.
                IDLE, DONE: begin
                    r_done <= 1'b0;
                    if (Start) begin
                        r_acc    <= '0;
                        r_mcand  <= {{WIDTH{1'b0}}, A};
                        r_mplier <= B;
                        r_count  <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= RUN;
                    end else begin
                        r_busy   <= 1'b0;
                        r_state  <= IDLE;
                    end
                end

                RUN: begin
                    // AdderS already holds Acc + (bit ? Mcand : 0) for this
                    // iteration, so the accumulator just takes the sum.
                    r_acc    <= AdderS;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_count  <= r_count + CW'(1);
                    if (r_count == LAST_ITER) begin
                        // Final partial product: publish the sum directly so
                        // P is valid in the same cycle Done rises.
                        r_p     <= AdderS;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_multiplier.sv
module tb_shift_add_multiplier;

    localparam int WIDTH = 4;

    logic              Clock;
    logic              Reset;
    logic              Start;
    logic [WIDTH-1:0]  A;
    logic [WIDTH-1:0]  B;
    logic [7:0]        AdderA;
    logic [7:0]        AdderB;
    logic [7:0]        AdderS;
    logic [7:0]        P;
    logic              Busy;
    logic              Done;

    int passed = 0;
    int total  = 0;
    int exp_p  = 0;

    shift_add_multiplier #(.WIDTH(WIDTH)) dut (
        .Clock  (Clock),
        .Reset  (Reset),
        .Start  (Start),
        .A      (A),
        .B      (B),
        .AdderA (AdderA),
        .AdderB (AdderB),
        .AdderS (AdderS),
        .P      (P),
        .Busy   (Busy),
        .Done   (Done)
    );

    // Stand-in for the external 8-bit ripple adder: carry-in 0, carry-out dropped.
    assign AdderS = AdderA + AdderB;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Outputs in IDLE: nothing running, adder operands quiet, P unchanged.
    task automatic idle_check(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge Clock);
            chk("idle_busy", 16'(Busy), 16'd0);
            chk("idle_done", 16'(Done), 16'd0);
            chk("idle_adder_a", 16'(AdderA), 16'd0);
            chk("idle_adder_b", 16'(AdderB), 16'd0);
            chk("idle_p", 16'(P), 16'(exp_p));
        end
    endtask

    // Called at a negedge with the DUT in IDLE or DONE. Launches a*b and
    // checks every cycle until the Done cycle, where it returns (still at the
    // negedge) so the caller may chain another op back-to-back.
    // With poke set, Start is re-asserted mid-RUN with other operands.
    task automatic op(input int a, input int b, input bit poke);
        int exp_aa;
        int exp_ab;
        Start = 1'b1;
        A = 4'(a);
        B = 4'(b);
        for (int i = 0; i < WIDTH; i++) begin
            @(negedge Clock);
            if (i == 0) begin
                Start = 1'b0;
                A = 4'($urandom);
                B = 4'($urandom);
            end
            if (poke && i == 1) begin
                Start = 1'b1;
                A = 4'd7;
                B = 4'd7;
            end else if (poke && i == 2) begin
                Start = 1'b0;
            end
            // Iteration i: accumulator holds the sum of partial products for
            // multiplier bits below i; operand B is a<<i if bit i of b is set.
            exp_aa = (a * (b % (1 << i))) & 8'hFF;
            exp_ab = (((b >> i) & 1) != 0) ? ((a << i) & 8'hFF) : 0;
            chk("run_busy", 16'(Busy), 16'd1);
            chk("run_done", 16'(Done), 16'd0);
            chk("run_adder_a", 16'(AdderA), 16'(exp_aa));
            chk("run_adder_b", 16'(AdderB), 16'(exp_ab));
            chk("run_p_held", 16'(P), 16'(exp_p));
        end
        @(negedge Clock);
        exp_p = a * b;
        chk("done_pulse", 16'(Done), 16'd1);
        chk("done_busy", 16'(Busy), 16'd0);
        chk("done_p", 16'(P), 16'(exp_p));
        chk("done_adder_a", 16'(AdderA), 16'd0);
        chk("done_adder_b", 16'(AdderB), 16'd0);
    endtask

    initial begin
        int ra;
        int rb;

        Reset = 1'b1;
        Start = 1'b0;
        A = '0;
        B = '0;
        #1;
        chk("reset_p", 16'(P), 16'd0);
        chk("reset_busy", 16'(Busy), 16'd0);
        chk("reset_done", 16'(Done), 16'd0);
        chk("reset_adder_a", 16'(AdderA), 16'd0);
        chk("reset_adder_b", 16'(AdderB), 16'd0);
        @(negedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
        idle_check(2);

        // Directed operand patterns
        op(3, 5, 1'b0);
        idle_check(1);
        op(15, 15, 1'b0);
        idle_check(1);
        op(0, 13, 1'b0);
        idle_check(1);
        op(9, 1, 1'b0);
        idle_check(1);

        // Start pulsed during RUN must be ignored: one Done, P=15, then IDLE
        op(3, 5, 1'b1);
        idle_check(2);

        // Back-to-back: Start held in the DONE cycle of 2*6
        op(2, 6, 1'b0);
        op(4, 4, 1'b0);
        idle_check(1);

        // Asynchronous reset mid-operation
        op(5, 5, 1'b0);
        idle_check(1);
        Start = 1'b1;
        A = 4'd6;
        B = 4'd6;
        @(posedge Clock);
        @(negedge Clock);
        Start = 1'b0;
        @(posedge Clock);
        @(posedge Clock);
        #3;
        Reset = 1'b1;
        #1;
        exp_p = 0;
        chk("async_reset_p", 16'(P), 16'd0);
        chk("async_reset_busy", 16'(Busy), 16'd0);
        chk("async_reset_done", 16'(Done), 16'd0);
        @(negedge Clock);
        Reset = 1'b0;
        idle_check(6);
        op(2, 3, 1'b0);
        idle_check(1);

        // Randomized operands, randomly chained back-to-back or with a gap
        for (int n = 0; n < 25; n++) begin
            ra = int'($urandom_range(0, 15));
            rb = int'($urandom_range(0, 15));
            op(ra, rb, 1'b0);
            if ($urandom_range(0, 1) == 1) idle_check(1);
        end
        idle_check(1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
